// File: rtl/audio_slot_sched.sv
// Time-slot scheduler sharing one audio DAC input among four latched sources.
// Define AUDIO_SLOT_SKIP_EN to skip disabled sources; default rotates all four slots.
module audio_slot_sched #(
    parameter int unsigned SLOT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic [3:0] en,
    input  logic [3:0] ld,
    input  logic [5:0] src0,
    input  logic [5:0] src1,
    input  logic [5:0] src2,
    input  logic [5:0] src3,
    output logic [5:0] dacDi,
    output logic [1:0] slot,
    output logic       slotStb
);

    localparam int unsigned   CW       = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    slot_q;
    logic [5:0]    dac_q;
    logic          stb_q;
    logic [5:0]    hold_q [4];

    logic [1:0]    slot_first_d;
    logic [1:0]    slot_next_d;
    logic [5:0]    dac_first_d;
    logic [5:0]    dac_next_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            if (ld[0]) hold_q[0] <= src0;
            if (ld[1]) hold_q[1] <= src1;
            if (ld[2]) hold_q[2] <= src2;
            if (ld[3]) hold_q[3] <= src3;
        end
    end

`ifdef AUDIO_SLOT_SKIP_EN
    logic [1:0] cand;

    // Later loop iterations win, so the lowest index / smallest offset has priority;
    // offset 4 wraps back onto the current slot when it is the only one enabled.
    always_comb begin
        slot_first_d = '0;
        slot_next_d  = slot_q;
        cand         = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            if (en[3 - j]) slot_first_d = 2'(3 - j);
        end
        for (int unsigned j = 0; j < 4; j++) begin
            cand = slot_q + 2'(4 - j);
            if (en[cand]) slot_next_d = cand;
        end
        dac_first_d = hold_q[slot_first_d];
        dac_next_d  = hold_q[slot_next_d];
    end
`else
    always_comb begin
        slot_first_d = '0;
        slot_next_d  = slot_q + 2'd1;
        dac_first_d  = en[0] ? hold_q[0] : '0;
        dac_next_d   = en[slot_next_d] ? hold_q[slot_next_d] : '0;
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            slot_q  <= '0;
            dac_q   <= '0;
            stb_q   <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    dac_q <= '0;
                    if (en != '0) begin
                        state_q <= RUN;
                        slot_q  <= slot_first_d;
                        dac_q   <= dac_first_d;
                        stb_q   <= 1'b1;
                    end
                end
                RUN: begin
                    if (ce) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q <= '0;
                            if (en == '0) begin
                                state_q <= IDLE;
                                dac_q   <= '0;
                            end else begin
                                slot_q <= slot_next_d;
                                dac_q  <= dac_next_d;
                                stb_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dacDi   = dac_q;
    assign slot    = slot_q;
    assign slotStb = stb_q;

endmodule
